uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a mid-bit majority-vote sampler, configurable frame format and a show-ahead receive FIFO. Sits between the `rx` pin and the memory-mapped UART peripheral of the RISC_V_Single_Cycle core. It replaces the fixed 8N1, single-byte receive path with one that tolerates CPU read latency and reports line errors.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per bit (50 MHz / 9600 baud); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, ≥ 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only with `UART_RX_PARITY_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `rd_en` in 1: pop the FIFO head. Ignored when `rx_valid` = 0.
- `rd_data` out DATA_BITS: FIFO head (show-ahead). Reset value 0.
- `rx_valid` out 1: FIFO not empty. Reset value 0.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH entries. Reset value 0.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low. Reset value 0.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Tied 0 without the macro. Reset value 0.
- `overrun` out 1: one-cycle pulse when a good frame is dropped because the FIFO is full. Reset value 0.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised `rxs`.
- **Bit counter:** `bcnt` runs 0..CLKS_PER_BIT-1. The sample point is at `bcnt` = CLKS_PER_BIT/2.
  - The bit value is the majority of `rxs` at counts CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1.
  - The FSM acts on the vote at count CLKS_PER_BIT/2+1.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: a 1→0 edge of `rxs` clears `bcnt` and moves to START.
  - START: vote = 1 is a glitch; return to IDLE with no error. Vote = 0 moves to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit, go to PARITY (macro) or STOP.
  - PARITY: compare the received parity bit against the computed parity; the result is held until the end of STOP.
  - STOP: check STOP_BITS stop bits.
    - Any stop bit voting 0: pulse `frame_err`, discard the frame, go to BREAK.
    - Otherwise, at the last stop bit's decision point:
      - parity bad → pulse `parity_err`, discard the frame;
      - parity good and FIFO full → pulse `overrun`, discard the frame;
      - parity good and FIFO not full → push the frame.
    - In every non-break case, return to IDLE.
  - BREAK: wait until `rxs` = 1, then go to IDLE. No new start bit is detected while in BREAK.
- When a frame has both a frame error and a parity error, only `frame_err` pulses.
- **FIFO:** circular buffer with read and write pointers one bit wider than log2(FIFO_DEPTH), so full and empty are distinguished by the extra bit. Pointers wrap naturally.
  - Push and pop in the same cycle: both happen, including when the FIFO is full (the pop frees the slot).
  - `rd_en` while empty: no effect, pointers unchanged.

## Timing
- The FSM sees the line 2 cycles after a change on `rx` (synchroniser).
- A push occurs at the decision point of the last stop bit:
  - (1 + DATA_BITS + P + STOP_BITS − 1) × CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles after the START transition;
  - P = 1 with the macro, 0 without.
- `rx_valid`, `fifo_full` and the new `rd_data` are registered: they update on the edge following the push or pop.
- Error pulses assert on the cycle after the decision point and last exactly 1 cycle.
- Back-to-back frames are accepted: a start edge arriving in IDLE immediately after STOP is detected.
- Reset asserted mid-frame:
  - FSM goes to IDLE, FIFO is emptied and the synchroniser is set to 1, all asynchronously;
  - the partial frame is lost;
  - if the line is still low at deassertion, no start edge is seen until the line returns high and falls again.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is compiled in. Each frame carries one parity bit after the data bits, checked against `PARITY_ODD`; `parity_err` is live.
- **Macro undefined:** frames carry no parity bit. The PARITY state and parity logic are absent, and `parity_err` is constant 0.

## Test plan
All scenarios use CLKS_PER_BIT = 16, DATA_BITS = 8, STOP_BITS = 1, FIFO_DEPTH = 4.
- **Single frame:** send 0x03 as 8N1 → `rx_valid` rises exactly at the computed push latency + 1; `rd_data` = 0x03; pulse `rd_en` → `rx_valid` = 0.
- **Glitch rejection:** hold `rx` low for 4 cycles, then high → FSM returns to IDLE; no push; no error pulses.
- **Framing error and break:** send 0x55 with the stop bit low, then hold `rx` low for 40 cycles → one `frame_err` pulse; FIFO empty; a following good 0xAA is received correctly.
- **Overrun:** send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads → `fifo_full` = 1 after the 4th frame; `overrun` pulses once on the 5th; four reads return 0x11, 0x22, 0x33, 0x44.
- **Pop/push when full:** with the FIFO full, assert `rd_en` on the exact push cycle of 0x66 → no `overrun`; the FIFO then holds 0x22, 0x33, 0x44, 0x66.
- **Parity (macro, even):** send 0xA5 with parity bit 1 → `parity_err` pulses, nothing pushed. Send 0xA5 with parity bit 0 → 0xA5 is received.
- **Reset mid-frame:** assert `reset` during DATA → all outputs 0; the next 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receiver (majority-vote mid-bit sampler) feeding a
//            show-ahead receive FIFO. Define UART_RX_PARITY_EN for parity.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rx_valid,
    output logic                 fifo_full,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int              c_BW        = $clog2(CLKS_PER_BIT);
    localparam int              c_AW        = $clog2(FIFO_DEPTH);
    localparam int              c_PW        = c_AW + 1;
    localparam logic [c_BW-1:0] c_CNT_LAST  = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_SAMPLE_0  = c_BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BW-1:0] c_SAMPLE_1  = c_BW'(CLKS_PER_BIT / 2);
    localparam logic [c_BW-1:0] c_DECIDE    = c_BW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_BW-1:0]      r_bcnt;
    logic [3:0]           r_bitn;
    logic                 r_v0;
    logic                 r_v1;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 r_sync1;
    logic                 r_rxs;
    logic                 r_rxs_prev;
    logic [1:0]           r_live;

    logic                 w_fall;
    logic                 w_decide;
    logic                 w_vote;
    logic                 w_pop;
    logic                 w_good;
    logic                 w_push;
    logic                 w_overrun;
    logic                 w_par_bad;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]      r_wr_ptr;
    logic [c_PW-1:0]      r_rd_ptr;
    logic [c_PW-1:0]      w_wr_next;
    logic [c_PW-1:0]      w_rd_next;
    logic [DATA_BITS-1:0] w_head;
    logic [DATA_BITS-1:0] r_rd_data;
    logic                 r_valid;
    logic                 r_full;

`ifdef UART_RX_PARITY_EN
    localparam logic c_PAR_ODD = (PARITY_ODD != 0);
    logic r_par_bad;
    logic r_parity_err;
    assign w_par_bad  = r_par_bad;
    assign parity_err = r_parity_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = (PARITY_ODD != 0);
    assign w_par_bad       = 1'b0;
    assign parity_err      = 1'b0;
`endif

    // r_live qualifies r_rxs_prev so a line held low across reset release
    // is not mistaken for a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b0;
            r_live     <= 2'b00;
        end else begin
            r_sync1    <= rx;
            r_rxs      <= r_sync1;
            r_live     <= {r_live[0], 1'b1};
            r_rxs_prev <= r_rxs & r_live[1];
        end
    end

    assign w_fall    = r_rxs_prev & ~r_rxs;
    assign w_decide  = (r_bcnt == c_DECIDE);
    assign w_vote    = (r_v0 & r_v1) | (r_v0 & r_rxs) | (r_v1 & r_rxs);
    assign w_pop     = rd_en & r_valid;
    assign w_good    = (r_state == S_STOP) & w_decide & w_vote
                     & (r_bitn == c_STOP_LAST) & ~w_par_bad;
    assign w_push    = w_good & (~r_full | w_pop);
    assign w_overrun = w_good & r_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_bcnt       <= '0;
            r_bitn       <= '0;
            r_v0         <= 1'b1;
            r_v1         <= 1'b1;
            r_shreg      <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            r_bcnt <= (r_bcnt == c_CNT_LAST) ? '0 : r_bcnt + 1'b1;
            if (r_bcnt == c_SAMPLE_0) r_v0 <= r_rxs;
            if (r_bcnt == c_SAMPLE_1) r_v1 <= r_rxs;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_bcnt  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_bitn <= '0;
                    if (w_decide) r_state <= w_vote ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
                        if (r_bitn == c_DATA_LAST) begin
                            r_bitn  <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bitn <= r_bitn + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_decide) begin
                        r_par_bad <= ^{r_shreg, w_vote, c_PAR_ODD};
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_decide) begin
                        if (!w_vote) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end else if (r_bitn == c_STOP_LAST) begin
                            r_overrun    <= w_overrun;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= r_par_bad;
`endif
                            r_state      <= S_IDLE;
                        end else begin
                            r_bitn <= r_bitn + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (r_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_wr_next = r_wr_ptr + c_PW'(w_push);
    assign w_rd_next = r_rd_ptr + c_PW'(w_pop);
    // A push landing in the slot that becomes the head bypasses the array.
    assign w_head    = (w_push && (w_rd_next[c_AW-1:0] == r_wr_ptr[c_AW-1:0]))
                     ? r_shreg : r_mem[w_rd_next[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= r_shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_wr_ptr  <= w_wr_next;
            r_rd_ptr  <= w_rd_next;
            r_valid   <= (w_wr_next != w_rd_next);
            r_full    <= (w_wr_next[c_AW] != w_rd_next[c_AW])
                      && (w_wr_next[c_AW-1:0] == w_rd_next[c_AW-1:0]);
            r_rd_data <= w_head;
        end
    end

    assign rd_data   = r_rd_data;
    assign rx_valid  = r_valid;
    assign fifo_full = r_full;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=16, 8N1, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // START is entered on the 3rd rising edge after the start bit is driven;
    // rx_valid is seen one edge after the last stop bit's decision cycle.
    localparam int PUSH_SEEN = 3 + (NBITS - 1) * CPB + CPB / 2 + 1 + 1;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int         total = 0;
    int         bad   = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_ovr  = 0;
    logic [7:0] exp_q[$];
    logic       unused_tb_par;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4),
        .PARITY_ODD   (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_valid   (rx_valid),
        .fifo_full  (fifo_full),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted read and counts pulses.
    initial begin
        logic pf = 1'b0;
        logic pp = 1'b0;
        logic po = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (frame_err) begin
                n_ferr++;
                check("frame_err_width", int'(pf), 0);
            end
            if (parity_err) begin
                n_perr++;
                check("parity_err_width", int'(pp), 0);
            end
            if (overrun) begin
                n_ovr++;
                check("overrun_width", int'(po), 0);
            end
            pf = frame_err;
            pp = parity_err;
            po = overrun;
            if (rd_en && rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_scoreboard", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", int'(rd_data), int'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame bit-by-bit on negedges; optionally pulses rd_en at
    // frame-relative cycle pop_at; reports first cycle rx_valid was seen high.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int pop_at, output int first_valid);
        logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, d, 1'b0};
`else
        bits = {stop, d, 1'b0};
        unused_tb_par = par;
`endif
        first_valid = -1;
        for (int c = 0; c < NBITS * CPB; c++) begin
            @(negedge clk);
            if (first_valid < 0 && rx_valid) first_valid = c;
            rx = bits[c / CPB];
            if (c == pop_at) rd_en = 1'b1;
            else if (c == pop_at + 1) rd_en = 1'b0;
        end
    endtask

    task automatic send_good(input logic [7:0] d, input bit store);
        int fv;
        if (store) exp_q.push_back(d);
        send_frame(d, ^d, 1'b1, -1, fv);
    endtask

    task automatic read_one();
        int w = 0;
        while (!rx_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!rx_valid) begin
            check("read_timeout_rx_valid", 0, 1);
        end else begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
    endtask

    initial begin
        int fv;
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        unused_tb_par = 1'b0;
        reset = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        idle(3);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_fifo_full", int'(fifo_full), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_parity_err", int'(parity_err), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b1;
        idle(10);

        // Single frame with exact latency
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b0, 1'b1, -1, fv);
        check("single_valid_cycle", fv, PUSH_SEEN);
        check("single_rd_data_head", int'(rd_data), 8'h03);
        read_one();
        idle(1);
        check("single_empty_after_read", int'(rx_valid), 0);

        // Glitch rejection
        idle(10);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(60);
        check("glitch_no_push", int'(rx_valid), 0);
        check("glitch_no_frame_err", n_ferr, 0);
        check("glitch_no_overrun", n_ovr, 0);
        check("glitch_no_parity_err", n_perr, 0);

        // Framing error then break
        send_frame(8'h55, ^8'h55, 1'b0, -1, fv);
        idle(40);
        rx = 1'b1;
        idle(20);
        check("framing_err_count", n_ferr, 1);
        check("framing_fifo_empty", int'(rx_valid), 0);
        send_good(8'hAA, 1'b1);
        idle(4);
        read_one();
        idle(1);
        check("after_break_empty", int'(rx_valid), 0);

        // Overrun on fifth frame
        for (int i = 0; i < 4; i++) send_good(vals[i], 1'b1);
        check("overrun_full_after_4", int'(fifo_full), 1);
        send_good(8'h55, 1'b0);
        idle(4);
        check("overrun_count", n_ovr, 1);
        check("overrun_still_full", int'(fifo_full), 1);
        for (int i = 0; i < 4; i++) read_one();
        idle(1);
        check("overrun_drained", int'(rx_valid), 0);

        // Pop and push on the same cycle while full
        for (int i = 0; i < 4; i++) send_good(vals[i], 1'b1);
        check("popfull_full_before", int'(fifo_full), 1);
        exp_q.push_back(8'h66);
        send_frame(8'h66, ^8'h66, 1'b1, PUSH_SEEN - 1, fv);
        idle(4);
        check("popfull_no_overrun", n_ovr, 1);
        check("popfull_full_after", int'(fifo_full), 1);
        for (int i = 0; i < 4; i++) read_one();
        idle(1);
        check("popfull_drained", int'(rx_valid), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0xA5 has four ones, so the correct parity bit is 0
        send_frame(8'hA5, 1'b1, 1'b1, -1, fv);
        idle(4);
        check("parity_err_count", n_perr, 1);
        check("parity_bad_not_pushed", int'(rx_valid), 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, -1, fv);
        idle(4);
        read_one();
`endif

        // Reset in mid-frame with the line still low at release
        send_good(8'h5A, 1'b0);
        idle(4);
        check("pre_reset_valid", int'(rx_valid), 1);
        rx = 1'b0;
        idle(40);
        reset = 1'b0;
        #1;
        check("midreset_rd_data", int'(rd_data), 0);
        check("midreset_rx_valid", int'(rx_valid), 0);
        check("midreset_fifo_full", int'(fifo_full), 0);
        check("midreset_errs", int'({frame_err, parity_err, overrun}), 0);
        idle(2);
        reset = 1'b1;
        idle(30);
        rx = 1'b1;
        idle(200);
        check("no_ghost_frame_after_reset", int'(rx_valid), 0);
        check("no_frame_err_after_reset", n_ferr, 1);
        send_good(8'h3C, 1'b1);
        idle(4);
        read_one();
        idle(20);

        check("scoreboard_drained", exp_q.size(), 0);
`ifdef UART_RX_PARITY_EN
        check("final_parity_err_total", n_perr, 1);
`else
        check("final_parity_err_total", n_perr, 0);
`endif
        check("final_overrun_total", n_ovr, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
